iec_drive_sd_arb: RTL
=====================

IEC_DRIVE_SD_ARB -- requirements
Module: iec_drive_sd_arb

Interface
REQ-001 SHALL have parameter DRIVES, default 2, requested drive count; clamped internally to NDR = 1..4.
REQ-002 SHALL have parameter TIMEOUT, default 2^22, clk_sys cycles allowed from request to host ack.
REQ-003 SHALL have port clk_sys, in, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have ports drv_rd and drv_wr, in, NDR, per-drive read and write requests.
REQ-006 SHALL have port drv_lba[NDR], in, 32, per-drive LBA.
REQ-007 SHALL have port drv_blk_cnt[NDR], in, 6, per-drive block count.
REQ-008 SHALL have port drv_ack, out, NDR, per-drive ack; mirrors sd_ack for the granted drive only.
REQ-009 SHALL have port drv_buff_din[NDR], in, 8, per-drive write-data.
REQ-010 SHALL have port drv_buff_wr, out, NDR, sd_buff_wr gated to the granted drive.
REQ-011 SHALL have port img_mounted, in, NDR, per-drive mount strobe.
REQ-012 SHALL have ports sd_lba (out, 32), sd_blk_cnt (out, 6), sd_rd (out, 1), sd_wr (out, 1), sd_ack (in, 1), sd_buff_wr (in, 1) and sd_buff_din (out, 8), forming the host side.
REQ-013 SHALL have port busy, out, 1, high while a grant is held.
REQ-014 SHALL have port tmo_err, out, NDR, one-cycle pulse on timeout of that drive.

Function
REQ-015 SHALL implement states IDLE, REQ, XFER and DONE.
REQ-016 IDLE: if any drive requests, SHALL register grant using round-robin from (last_grant+1) mod NDR, latch that drive's lba, blk_cnt and op, and go to REQ.
REQ-017 Op selection: if drv_wr and drv_rd are both high for the granted drive, write SHALL win.
REQ-018 REQ: sd_rd or sd_wr SHALL be high from the cycle after grant; on sd_ack=1 go to XFER.
REQ-019 XFER: sd_rd and sd_wr SHALL be low; on sd_ack=0 go to DONE.
REQ-020 DONE: one cycle; SHALL update last_grant, then return to IDLE.
REQ-021 Minimum gap between consecutive grants SHALL be 1 IDLE cycle.
REQ-022 sd_lba, sd_blk_cnt and op SHALL stay latched and stable from REQ through DONE, independent of later drv_* changes.
REQ-023 sd_buff_din SHALL be drv_buff_din[grant] combinationally; when not busy, sd_buff_din=0.
REQ-024 drv_buff_wr[i] SHALL equal sd_buff_wr & busy & (grant==i).
REQ-025 drv_ack[i] SHALL equal sd_ack & busy & (grant==i).
REQ-026 Timeout: a counter SHALL clear on entry to REQ and count while in REQ.
REQ-027 On reaching TIMEOUT-1 without ack, the block SHALL drop sd_rd/sd_wr, pulse tmo_err[grant], and go to DONE.
REQ-028 The timeout counter SHALL saturate and never wrap.
REQ-029 img_mounted[grant] in REQ SHALL abort as for timeout, but without a tmo_err pulse.
REQ-030 img_mounted[grant] in XFER SHALL be ignored; the transfer completes.
REQ-031 A drive whose request drops while in REQ SHALL be treated as an abort (DONE, no error).
REQ-032 sd_ack high while in IDLE (stray ack) SHALL be ignored.
REQ-033 Requests from non-granted drives SHALL be held pending; none is lost.
REQ-034 Indices >= NDR SHALL never be granted.

Reset
REQ-035 Reset SHALL force state=IDLE, grant=0, last_grant=NDR-1, and counter=0.
REQ-036 During reset, outputs SHALL be sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, busy=0, tmo_err=0, drv_ack=0, drv_buff_wr=0.
REQ-037 Reset asserted mid-XFER SHALL take effect next cycle; host-side cleanup is the system's concern.

Structure
REQ-038 NDR clamp, state enum and the 32/6/8 width constants SHALL live in shared package iec_drive_pkg.
REQ-039 The round-robin picker SHALL be sub-module iec_rr_pick (NDR-bit request vector plus last index in, next index and valid out, combinational).

Verification
REQ-040 drv_rd=2'b01, lba=100, blk_cnt=1; host acks 3 cycles after sd_rd, holds ack 10 cycles -> sd_rd high 3 cycles, sd_lba=100, drv_ack[0] high 10 cycles, busy low after DONE.
REQ-041 drv_rd=2'b11 held continuously -> grants alternate 0,1,0,1 across four transfers.
REQ-042 Drive 1 drv_rd and drv_wr both high, lba=7 -> sd_wr=1, sd_rd=0, sd_lba=7.
REQ-043 TIMEOUT=16, no ack -> sd_rd drops after 16 REQ cycles, tmo_err=2'b01 for one cycle, next pending drive granted.
REQ-044 img_mounted[0] during REQ -> abort with no tmo_err; img_mounted[0] during XFER -> transfer completes and drv_ack unaffected.
REQ-045 Reset mid-XFER -> next cycle all outputs at reset values and state=IDLE.

Source files
------------

// File: rtl/iec_drive_pkg.sv
// Shared widths, state encoding, command payload and parameter helpers
// for the SD-card drive arbiter.
package iec_drive_pkg;

  localparam int unsigned LBA_W      = 32;
  localparam int unsigned BLK_W      = 6;
  localparam int unsigned DAT_W      = 8;
  localparam int unsigned MAX_DRIVES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // Command latched at grant and presented to the host until the grant ends.
  typedef struct packed {
    logic [LBA_W-1:0] lba;
    logic [BLK_W-1:0] blk_cnt;
  } sd_cmd_t;

  function automatic int unsigned ndr_clamp(input int drives);
    if (drives < 1) return 1;
    if (drives > int'(MAX_DRIVES)) return MAX_DRIVES;
    return $unsigned(drives);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iec_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last+1) mod N.
module iec_rr_pick
  import iec_drive_pkg::*;
#(
  parameter int unsigned  N  = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] pick_c_o,
  output logic          valid_c_o
);

  always_comb begin
    logic [IW:0] idx;
    pick_c_o  = '0;
    valid_c_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (IW+1)'(last_i) + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!valid_c_o && req_i[idx[IW-1:0]]) begin
        valid_c_o = 1'b1;
        pick_c_o  = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/iec_drive_sd_arb.sv
// Arbitrates up to four emulated drives onto a single SD host port, one
// transfer at a time, with request timeout and image-change abort.
module iec_drive_sd_arb
  import iec_drive_pkg::*;
#(
  parameter int           DRIVES  = 2,
  parameter int           TIMEOUT = 2**22,
  localparam int unsigned NDR     = ndr_clamp(DRIVES)
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NDR-1:0]     drv_rd,
  input  logic [NDR-1:0]     drv_wr,
  input  logic [LBA_W-1:0]   drv_lba      [NDR],
  input  logic [BLK_W-1:0]   drv_blk_cnt  [NDR],
  output logic [NDR-1:0]     drv_ack,
  input  logic [DAT_W-1:0]   drv_buff_din [NDR],
  output logic [NDR-1:0]     drv_buff_wr,
  input  logic [NDR-1:0]     img_mounted,
  output logic [LBA_W-1:0]   sd_lba,
  output logic [BLK_W-1:0]   sd_blk_cnt,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  output logic [DAT_W-1:0]   sd_buff_din,
  output logic               busy,
  output logic [NDR-1:0]     tmo_err
);

  localparam int unsigned TMO = (TIMEOUT < 1) ? 1 : $unsigned(TIMEOUT);
  localparam int unsigned CW  = $clog2(TMO + 1);
  localparam int unsigned GW  = idx_w(NDR);

  arb_state_e     state_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  last_q;
  sd_cmd_t        cmd_q;
  logic [CW-1:0]  cnt_q;
  logic           sd_rd_q;
  logic           sd_wr_q;
  logic           busy_q;
  logic [NDR-1:0] tmo_q;

  logic [NDR-1:0] req_vec;
  logic [GW-1:0]  pick;
  logic           pick_valid;
  logic           grant_req;
  logic           grant_mnt;
  logic           tmo_hit;

  assign req_vec   = drv_rd | drv_wr;
  assign grant_req = req_vec[grant_q];
  assign grant_mnt = img_mounted[grant_q];
  assign tmo_hit   = (cnt_q == CW'(TMO - 1));

  iec_rr_pick #(.N(NDR)) u_pick (
    .req_i     (req_vec),
    .last_i    (last_q),
    .pick_c_o  (pick),
    .valid_c_o (pick_valid)
  );

  // Grant sequencing; host strobes drop on ack, abort or timeout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NDR - 1);
      cmd_q   <= '0;
      cnt_q   <= '0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      tmo_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q       <= pick;
            cmd_q.lba     <= drv_lba[pick];
            cmd_q.blk_cnt <= drv_blk_cnt[pick];
            sd_wr_q       <= drv_wr[pick];
            sd_rd_q       <= ~drv_wr[pick];
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= ST_XFER;
          end else if (grant_mnt || !grant_req) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= ST_DONE;
          end else if (tmo_hit) begin
            sd_rd_q        <= 1'b0;
            sd_wr_q        <= 1'b0;
            tmo_q[grant_q] <= 1'b1;
            state_q        <= ST_DONE;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_XFER: begin
          if (!sd_ack) state_q <= ST_DONE;
        end
        ST_DONE: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Host handshake and data are steered to the granted drive only.
  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    sd_buff_din = '0;
    if (busy_q) begin
      drv_ack[grant_q]     = sd_ack;
      drv_buff_wr[grant_q] = sd_buff_wr;
      sd_buff_din          = drv_buff_din[grant_q];
    end
  end

  assign sd_lba     = cmd_q.lba;
  assign sd_blk_cnt = cmd_q.blk_cnt;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign busy       = busy_q;
  assign tmo_err    = tmo_q;

endmodule
